// File: rtl/sync_fifo_param.sv
// sync_fifo_param: parameterised single-clock FIFO with registered read data and a valid strobe.
// Define SYNC_FIFO_ERR_EN to add the err_clr input and the sticky overflow/underflow outputs.
module sync_fifo_param #(
    parameter int DATA_W   = 8,
    parameter int DEPTH    = 8,
    parameter int AF_LEVEL = 6,
    parameter int AE_LEVEL = 1
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    flush,
    input  logic                    wr_en,
    input  logic [DATA_W-1:0]       wr_data,
    input  logic                    rd_en,
    output logic [DATA_W-1:0]       rd_data,
    output logic                    rd_valid,
    output logic                    full,
    output logic                    empty,
    output logic                    almost_full,
    output logic                    almost_empty,
    output logic [$clog2(DEPTH):0]  count
`ifdef SYNC_FIFO_ERR_EN
    ,
    input  logic                    err_clr,
    output logic                    overflow,
    output logic                    underflow
`endif
);

    localparam int ADDR_W = $clog2(DEPTH);
    localparam logic [ADDR_W:0] DEPTH_C = (ADDR_W+1)'(DEPTH);
    localparam logic [ADDR_W:0] AF_C    = (ADDR_W+1)'(AF_LEVEL);
    localparam logic [ADDR_W:0] AE_C    = (ADDR_W+1)'(AE_LEVEL);

    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [ADDR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [ADDR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [ADDR_W:0]   count_q, count_d;
    logic [DATA_W-1:0] rd_data_q;
    logic              rd_valid_q;
    logic              rd_acc;
    logic              wr_acc;

    assign empty        = (count_q == '0);
    assign full         = (count_q == DEPTH_C);
    assign almost_full  = (count_q >= AF_C);
    assign almost_empty = (count_q <= AE_C);
    assign count        = count_q;
    assign rd_data      = rd_data_q;
    assign rd_valid     = rd_valid_q;

    // A full FIFO still takes a write when a read frees a slot in the same cycle.
    assign rd_acc = rd_en & ~empty;
    assign wr_acc = wr_en & (~full | rd_acc);

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (wr_acc) wr_ptr_d = wr_ptr_q + ADDR_W'(1);
            if (rd_acc) rd_ptr_d = rd_ptr_q + ADDR_W'(1);
            unique case ({wr_acc, rd_acc})
                2'b10:   count_d = count_q + (ADDR_W+1)'(1);
                2'b01:   count_d = count_q - (ADDR_W+1)'(1);
                default: count_d = count_q;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            rd_data_q  <= '0;
            rd_valid_q <= 1'b0;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            rd_valid_q <= rd_acc & ~flush;
            if (rd_acc && !flush) rd_data_q <= mem_q[rd_ptr_q];
        end
    end

    // Storage has no reset so it maps onto block RAM.
    always_ff @(posedge clk) begin
        if (wr_acc && !flush) mem_q[wr_ptr_q] <= wr_data;
    end

`ifdef SYNC_FIFO_ERR_EN
    logic overflow_q, overflow_d;
    logic underflow_q, underflow_d;

    // A new error event in the clearing cycle keeps the flag set.
    always_comb begin
        overflow_d  = (overflow_q  & ~err_clr) | (wr_en & ~wr_acc);
        underflow_d = (underflow_q & ~err_clr) | (rd_en & empty);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
        end else begin
            overflow_q  <= overflow_d;
            underflow_q <= underflow_d;
        end
    end

    assign overflow  = overflow_q;
    assign underflow = underflow_q;
`endif

endmodule

// File: tb/tb_sync_fifo_param.sv
// Testbench for sync_fifo_param: directed scenarios plus random traffic against a queue model.
module tb_sync_fifo_param;
    localparam int DATA_W = 8;
    localparam int DEPTH  = 8;
    localparam int AF     = 6;
    localparam int AE     = 1;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              flush = 1'b0;
    logic              wr_en = 1'b0;
    logic [DATA_W-1:0] wr_data = '0;
    logic              rd_en = 1'b0;
    logic              err_clr = 1'b0;
    logic [DATA_W-1:0] rd_data;
    logic              rd_valid, full, empty, almost_full, almost_empty;
    logic [3:0]        count;
`ifdef SYNC_FIFO_ERR_EN
    logic              overflow, underflow;
`endif

    sync_fifo_param #(.DATA_W(DATA_W), .DEPTH(DEPTH), .AF_LEVEL(AF), .AE_LEVEL(AE)) dut (
        .clk(clk), .rst(rst), .flush(flush),
        .wr_en(wr_en), .wr_data(wr_data), .rd_en(rd_en),
        .rd_data(rd_data), .rd_valid(rd_valid),
        .full(full), .empty(empty),
        .almost_full(almost_full), .almost_empty(almost_empty),
        .count(count)
`ifdef SYNC_FIFO_ERR_EN
        , .err_clr(err_clr), .overflow(overflow), .underflow(underflow)
`endif
    );

    always #5 clk = ~clk;

    // Reference model: the FIFO contents as a queue plus the visible registered state.
    logic [DATA_W-1:0] q[$];
    logic [DATA_W-1:0] m_rd_data = '0;
    logic              m_rd_valid = 1'b0;
    logic              m_ovf = 1'b0;
    logic              m_unf = 1'b0;
    int                checks = 0;
    int                errors = 0;
    bit                chk_en = 1'b0;
    int                max_count;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        q.delete();
        m_rd_data  = '0;
        m_rd_valid = 1'b0;
        m_ovf      = 1'b0;
        m_unf      = 1'b0;
    endtask

    task automatic model_step(input bit wr, input logic [DATA_W-1:0] d, input bit rd,
                              input bit fl, input bit clr);
        bit rd_ok, wr_ok, was_empty;
        was_empty = (q.size() == 0);
        rd_ok = rd && !was_empty;
        wr_ok = wr && (q.size() < DEPTH || rd_ok);
        m_ovf = (m_ovf && !clr) || (wr && !wr_ok);
        m_unf = (m_unf && !clr) || (rd && was_empty);
        if (fl) begin
            q.delete();
            m_rd_valid = 1'b0;
        end else begin
            m_rd_valid = rd_ok;
            if (rd_ok) m_rd_data = q.pop_front();
            if (wr_ok) q.push_back(d);
        end
    endtask

    // One clock of stimulus: drive inputs, advance the model at the edge, return at the next negedge.
    task automatic cycle(input bit wr, input logic [DATA_W-1:0] d, input bit rd,
                         input bit fl = 1'b0, input bit clr = 1'b0);
        wr_en = wr; wr_data = d; rd_en = rd; flush = fl; err_clr = clr;
        @(posedge clk);
        model_step(wr, d, rd, fl, clr);
        @(negedge clk);
        wr_en = 1'b0; rd_en = 1'b0; flush = 1'b0; err_clr = 1'b0;
        if (int'(count) > max_count) max_count = int'(count);
    endtask

    always @(negedge clk) begin
        if (chk_en) begin
            int n;
            n = q.size();
            chk("count", 32'(count), 32'(n));
            chk("empty", 32'(empty), 32'(n == 0));
            chk("full", 32'(full), 32'(n == DEPTH));
            chk("almost_full", 32'(almost_full), 32'(n >= AF));
            chk("almost_empty", 32'(almost_empty), 32'(n <= AE));
            chk("rd_valid", 32'(rd_valid), 32'(m_rd_valid));
            chk("rd_data", 32'(rd_data), 32'(m_rd_data));
`ifdef SYNC_FIFO_ERR_EN
            chk("overflow", 32'(overflow), 32'(m_ovf));
            chk("underflow", 32'(underflow), 32'(m_unf));
`endif
        end
    end

    initial begin
        model_reset();
        #12 rst = 1'b0;
        @(negedge clk);
        chk("reset_count", 32'(count), 32'd0);
        chk("reset_empty", 32'(empty), 32'd1);
        chk("reset_ae", 32'(almost_empty), 32'd1);
        chk("reset_full", 32'(full), 32'd0);
        chk_en = 1'b1;

        // Reset mid-operation, asserted between edges.
        for (int i = 0; i < 5; i++) cycle(1'b1, 8'h11 + 8'(i), 1'b0);
        cycle(1'b0, 8'h00, 1'b1);
        chk("pre_rst_rd_data", 32'(rd_data), 32'h11);
        #2 rst = 1'b1;
        #1;
        chk("rst_count", 32'(count), 32'd0);
        chk("rst_empty", 32'(empty), 32'd1);
        chk("rst_rd_data", 32'(rd_data), 32'd0);
        model_reset();
        #1 rst = 1'b0;
        cycle(1'b1, 8'h3C, 1'b0);
        chk("rst_first_entry0", 32'(dut.mem_q[0]), 32'h3C);
        cycle(1'b0, 8'h00, 1'b1);
        chk("rst_readback", 32'(rd_data), 32'h3C);

        // Fill, then an overflowing write.
        for (int i = 1; i <= 8; i++) cycle(1'b1, 8'(i), 1'b0);
        chk("fill_count", 32'(count), 32'd8);
        cycle(1'b1, 8'hFF, 1'b0);
        chk("fill_drop_count", 32'(count), 32'd8);
`ifdef SYNC_FIFO_ERR_EN
        chk("fill_overflow", 32'(overflow), 32'd1);
`endif

        // Drain, then one read on empty.
        for (int i = 1; i <= 8; i++) begin
            cycle(1'b0, 8'h00, 1'b1);
            chk("drain_data", 32'(rd_data), 32'(i));
        end
        cycle(1'b0, 8'h00, 1'b1);
        chk("underrun_valid", 32'(rd_valid), 32'd0);
        chk("underrun_hold", 32'(rd_data), 32'h08);
`ifdef SYNC_FIFO_ERR_EN
        chk("underrun_flag", 32'(underflow), 32'd1);
        cycle(1'b0, 8'h00, 1'b0, 1'b0, 1'b1);
        chk("err_clr_ovf", 32'(overflow), 32'd0);
`endif

        // Full FIFO with simultaneous write and read.
        for (int i = 1; i <= 8; i++) cycle(1'b1, 8'(i), 1'b0);
        cycle(1'b1, 8'hA5, 1'b1);
        chk("fullrw_count", 32'(count), 32'd8);
        chk("fullrw_data", 32'(rd_data), 32'h01);
`ifdef SYNC_FIFO_ERR_EN
        chk("fullrw_no_ovf", 32'(overflow), 32'd0);
`endif
        for (int i = 0; i < 8; i++) cycle(1'b0, 8'h00, 1'b1);
        chk("fullrw_last", 32'(rd_data), 32'hA5);

        // Wrap with alternating write/read pairs.
        max_count = 0;
        for (int i = 0; i < 20; i++) begin
            cycle(1'b1, 8'(i), 1'b0);
            cycle(1'b0, 8'h00, 1'b1);
            chk("wrap_data", 32'(rd_data), 32'(i));
        end
        chk("wrap_max_count", 32'(max_count), 32'd1);

        // Flush with a concurrent write, then error clear (a fresh event in the clear cycle wins).
        for (int i = 0; i < 4; i++) cycle(1'b1, 8'h40 + 8'(i), 1'b0);
        cycle(1'b1, 8'h99, 1'b0, 1'b1);
        chk("flush_count", 32'(count), 32'd0);
        chk("flush_empty", 32'(empty), 32'd1);
        chk("flush_rd_hold", 32'(rd_data), 32'h13);
        cycle(1'b0, 8'h00, 1'b1, 1'b0, 1'b1);
`ifdef SYNC_FIFO_ERR_EN
        chk("clr_set_wins", 32'(underflow), 32'd1);
        cycle(1'b0, 8'h00, 1'b0, 1'b0, 1'b1);
        chk("clr_unf", 32'(underflow), 32'd0);
`endif

        // Random traffic.
        for (int i = 0; i < 3000; i++) begin
            cycle($urandom_range(0, 99) < 55, 8'($urandom), $urandom_range(0, 99) < 50,
                  $urandom_range(0, 99) < 2, $urandom_range(0, 99) < 3);
        end

        chk_en = 1'b0;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
